// File: rtl/vec_xif_issue_queue.sv
// vec_xif_issue_queue
// Coprocessor-side front end of the X-interface. Decodes offloaded instructions
// for accept/writeback, buffers accepted ones with their operands until the CPU
// commits or kills them, and dispatches committed instructions in program order
// to the vector execution unit. Killed instructions are dropped silently.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   issue_*_i / issue_*_o  X-IF issue channel (valid/ready, instr, id, rs0, rs1,
//                          accept/writeback responses in the handshake cycle)
//   commit_*_i             X-IF commit channel (valid, id, kill)
//   disp_*_o / disp_ready_i  in-order dispatch to the vector unit
//   occupancy_o            number of live entries
//
// Entry state table
//   state       | meaning
//   E_FREE      | slot unused
//   E_WAIT      | accepted, waiting for commit or kill
//   E_COMMITTED | committed, dispatches when it reaches the head
//   E_KILLED    | killed, dropped without dispatch when it reaches the head
module vec_xif_issue_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned RFR_WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   issue_valid_i,
   output logic                   issue_ready_o,
   input  logic [31:0]            issue_instr_i,
   input  logic [ID_WIDTH-1:0]    issue_id_i,
   input  logic [RFR_WIDTH-1:0]   issue_rs0_i,
   input  logic [RFR_WIDTH-1:0]   issue_rs1_i,
   output logic                   issue_accept_o,
   output logic                   issue_writeback_o,
   input  logic                   commit_valid_i,
   input  logic [ID_WIDTH-1:0]    commit_id_i,
   input  logic                   commit_kill_i,
   output logic                   disp_valid_o,
   input  logic                   disp_ready_i,
   output logic [31:0]            disp_instr_o,
   output logic [ID_WIDTH-1:0]    disp_id_o,
   output logic [RFR_WIDTH-1:0]   disp_rs0_o,
   output logic [RFR_WIDTH-1:0]   disp_rs1_o,
   output logic [$clog2(DEPTH):0] occupancy_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {E_FREE, E_WAIT, E_COMMITTED, E_KILLED} ent_state_e;

   ent_state_e             st_q     [DEPTH];
   ent_state_e             st_d     [DEPTH];
   logic [31:0]            instr_q  [DEPTH];
   logic [ID_WIDTH-1:0]    id_q     [DEPTH];
   logic [RFR_WIDTH-1:0]   rs0_q    [DEPTH];
   logic [RFR_WIDTH-1:0]   rs1_q    [DEPTH];

   logic [PW-1:0]          head_q, head_d;
   logic [PW-1:0]          tail_q, tail_d;
   logic [PW:0]            count_q, count_d;

   logic                   disp_valid_q, disp_valid_d;
   logic [31:0]            disp_instr_q, disp_instr_d;
   logic [ID_WIDTH-1:0]    disp_id_q, disp_id_d;
   logic [RFR_WIDTH-1:0]   disp_rs0_q, disp_rs0_d;
   logic [RFR_WIDTH-1:0]   disp_rs1_q, disp_rs1_d;

   logic                   id_hit;
   logic                   is_opv;
   logic                   push;
   logic                   pop;
   ent_state_e             commit_st;

   // An ID is live while any non-free slot holds it, including a slot being
   // popped this cycle (no same-cycle reuse).
   always_comb begin
      id_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((st_q[i] != E_FREE) && (id_q[i] == issue_id_i)) id_hit = 1'b1;
      end
   end

   assign is_opv            = (issue_instr_i[6:0] == 7'h57);
   assign issue_ready_o     = (count_q != CNT_FULL);
   assign issue_accept_o    = issue_valid_i & is_opv & ~id_hit;
   assign issue_writeback_o = issue_accept_o & (issue_instr_i[14:12] == 3'b010) &
                              (issue_instr_i[31:26] == 6'b010000);

   assign push      = issue_valid_i & issue_ready_o & issue_accept_o;
   // disp_valid_q mirrors a committed head, so the two pop causes are exclusive.
   assign pop       = (disp_valid_q & disp_ready_i) | (st_q[head_q] == E_KILLED);
   assign commit_st = commit_kill_i ? E_KILLED : E_COMMITTED;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = st_q[i];

      if (commit_valid_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((st_q[i] == E_WAIT) && (id_q[i] == commit_id_i)) st_d[i] = commit_st;
         end
      end

      if (pop) st_d[head_q] = E_FREE;

      // Push never targets the popped slot: a push needs a non-full queue.
      if (push) begin
         if (commit_valid_i && (commit_id_i == issue_id_i)) st_d[tail_q] = commit_st;
         else                                               st_d[tail_q] = E_WAIT;
      end

      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

      disp_valid_d = (st_d[head_d] == E_COMMITTED);

      // When the queue drains and refills in one cycle the new head is still on
      // the issue inputs, not yet in the storage arrays.
      if (push && (head_d == tail_q)) begin
         disp_instr_d = issue_instr_i;
         disp_id_d    = issue_id_i;
         disp_rs0_d   = issue_rs0_i;
         disp_rs1_d   = issue_rs1_i;
      end else begin
         disp_instr_d = instr_q[head_d];
         disp_id_d    = id_q[head_d];
         disp_rs0_d   = rs0_q[head_d];
         disp_rs1_d   = rs1_q[head_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         disp_valid_q <= 1'b0;
         disp_instr_q <= '0;
         disp_id_q    <= '0;
         disp_rs0_q   <= '0;
         disp_rs1_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= st_d[i];
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         disp_valid_q <= disp_valid_d;
         if (disp_valid_d) begin
            disp_instr_q <= disp_instr_d;
            disp_id_q    <= disp_id_d;
            disp_rs0_q   <= disp_rs0_d;
            disp_rs1_q   <= disp_rs1_d;
         end
      end
   end

   // Payload storage needs no reset; slot state alone decides liveness.
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[tail_q] <= issue_instr_i;
         id_q[tail_q]    <= issue_id_i;
         rs0_q[tail_q]   <= issue_rs0_i;
         rs1_q[tail_q]   <= issue_rs1_i;
      end
   end

   assign disp_valid_o = disp_valid_q;
   assign disp_instr_o = disp_instr_q;
   assign disp_id_o    = disp_id_q;
   assign disp_rs0_o   = disp_rs0_q;
   assign disp_rs1_o   = disp_rs1_q;
   assign occupancy_o  = count_q;

endmodule

// File: tb/tb_vec_xif_issue_queue.sv
// Bench for vec_xif_issue_queue: directed scenarios followed by random traffic,
// all checked against an in-order queue model of the X-IF issue/commit rules.
module tb_vec_xif_issue_queue;

   localparam int DEPTH = 4;
   localparam int IDW   = 4;
   localparam int RW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   localparam logic [31:0] VADD  = 32'h02008057;
   localparam logic [31:0] VMVXS = 32'h42002057;
   localparam logic [31:0] ADDI  = 32'h00000013;

   localparam int S_WAIT = 1;
   localparam int S_CMT  = 2;
   localparam int S_KILL = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue_valid, issue_ready, issue_accept, issue_writeback;
   logic [31:0]     issue_instr;
   logic [IDW-1:0]  issue_id;
   logic [RW-1:0]   issue_rs0, issue_rs1;
   logic            commit_valid, commit_kill;
   logic [IDW-1:0]  commit_id;
   logic            disp_valid, disp_ready;
   logic [31:0]     disp_instr;
   logic [IDW-1:0]  disp_id;
   logic [RW-1:0]   disp_rs0, disp_rs1;
   logic [CW-1:0]   occupancy;

   always #5 clk = ~clk;

   vec_xif_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .RFR_WIDTH(RW)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .issue_valid_i     (issue_valid),
      .issue_ready_o     (issue_ready),
      .issue_instr_i     (issue_instr),
      .issue_id_i        (issue_id),
      .issue_rs0_i       (issue_rs0),
      .issue_rs1_i       (issue_rs1),
      .issue_accept_o    (issue_accept),
      .issue_writeback_o (issue_writeback),
      .commit_valid_i    (commit_valid),
      .commit_id_i       (commit_id),
      .commit_kill_i     (commit_kill),
      .disp_valid_o      (disp_valid),
      .disp_ready_i      (disp_ready),
      .disp_instr_o      (disp_instr),
      .disp_id_o         (disp_id),
      .disp_rs0_o        (disp_rs0),
      .disp_rs1_o        (disp_rs1),
      .occupancy_o       (occupancy)
   );

   typedef struct {
      logic [31:0]    instr;
      logic [IDW-1:0] id;
      logic [RW-1:0]  rs0;
      logic [RW-1:0]  rs1;
      int             st;
   } ent_t;

   ent_t mq[$];
   int   total = 0;
   int   bad   = 0;
   int   n_disp = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit id_live(input logic [IDW-1:0] id);
      foreach (mq[i]) if (mq[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: drive at the falling edge, check just after, then apply
   // the X-IF rules to the model at the rising edge.
   task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                       input logic [IDW-1:0] id, input logic [RW-1:0] a,
                       input logic [RW-1:0] b, input logic cv,
                       input logic [IDW-1:0] cid, input logic ck, input logic dr);
      bit   e_ready, e_acc, e_wb, e_dv, do_pop;
      ent_t ne;
      rst = r; issue_valid = iv; issue_instr = ins; issue_id = id;
      issue_rs0 = a; issue_rs1 = b; commit_valid = cv; commit_id = cid;
      commit_kill = ck; disp_ready = dr;
      #1;
      e_ready = (mq.size() != DEPTH);
      e_acc   = iv && (ins[6:0] == 7'h57) && !id_live(id);
      e_wb    = e_acc && (ins[14:12] == 3'b010) && (ins[31:26] == 6'b010000);
      e_dv    = (mq.size() > 0) && (mq[0].st == S_CMT);
      chk("issue_ready", 64'(issue_ready), 64'(e_ready));
      chk("issue_accept", 64'(issue_accept), 64'(e_acc));
      chk("issue_writeback", 64'(issue_writeback), 64'(e_wb));
      chk("disp_valid", 64'(disp_valid), 64'(e_dv));
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      if (e_dv) begin
         chk("disp_instr", 64'(disp_instr), 64'(mq[0].instr));
         chk("disp_id", 64'(disp_id), 64'(mq[0].id));
         chk("disp_rs0", 64'(disp_rs0), 64'(mq[0].rs0));
         chk("disp_rs1", 64'(disp_rs1), 64'(mq[0].rs1));
      end
      @(posedge clk);
      if (r) begin
         mq.delete();
      end else begin
         do_pop = (e_dv && dr) || ((mq.size() > 0) && (mq[0].st == S_KILL));
         if (e_dv && dr) n_disp++;
         if (cv) foreach (mq[i]) if (mq[i].st == S_WAIT && mq[i].id == cid)
            mq[i].st = ck ? S_KILL : S_CMT;
         if (do_pop) void'(mq.pop_front());
         if (iv && e_ready && e_acc) begin
            ne.instr = ins; ne.id = id; ne.rs0 = a; ne.rs1 = b;
            ne.st = (cv && cid == id) ? (ck ? S_KILL : S_CMT) : S_WAIT;
            mq.push_back(ne);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic dr);
      step(1'b0, 1'b0, 32'h0, '0, '0, '0, 1'b0, '0, 1'b0, dr);
   endtask

   task automatic iss(input logic [31:0] ins, input logic [IDW-1:0] id,
                      input logic [RW-1:0] a, input logic [RW-1:0] b, input logic dr);
      step(1'b0, 1'b1, ins, id, a, b, 1'b0, '0, 1'b0, dr);
   endtask

   task automatic cmt(input logic [IDW-1:0] cid, input logic ck, input logic dr);
      step(1'b0, 1'b0, 32'h0, '0, '0, '0, 1'b1, cid, ck, dr);
   endtask

   initial begin
      logic [31:0]    ins;
      logic [IDW-1:0] cid;
      int             waits[$];
      int             sel;

      rst = 1'b1; issue_valid = 1'b0; issue_instr = '0; issue_id = '0;
      issue_rs0 = '0; issue_rs1 = '0; commit_valid = 1'b0; commit_id = '0;
      commit_kill = 1'b0; disp_ready = 1'b0;
      @(negedge clk);

      // reset state
      step(1'b1, 1'b0, 32'h0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("rst_disp_instr", 64'(disp_instr), 64'h0);
      chk("rst_disp_id", 64'(disp_id), 64'h0);
      chk("rst_disp_rs", 64'({disp_rs0, disp_rs1}), 64'h0);

      // issue + commit into an empty queue, dispatch next cycle
      step(1'b0, 1'b1, VADD, 4'd3, 32'd5, 32'd7, 1'b1, 4'd3, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // decode: non-vector rejected, vmv.x.s writes back
      iss(ADDI, 4'd1, 32'd1, 32'd2, 1'b1);
      iss(VMVXS, 4'd6, 32'd8, 32'd9, 1'b1);
      cmt(4'd6, 1'b0, 1'b1);
      idle(1'b1);

      // in-order dispatch behind a waiting head
      iss(VADD, 4'd1, 32'h11, 32'h12, 1'b1);
      iss(VADD, 4'd2, 32'h21, 32'h22, 1'b1);
      iss(VADD, 4'd3, 32'h31, 32'h32, 1'b1);
      cmt(4'd3, 1'b0, 1'b1);
      cmt(4'd2, 1'b0, 1'b1);
      idle(1'b1);
      cmt(4'd1, 1'b0, 1'b1);
      repeat (4) idle(1'b1);
      chk("inorder_disp_count", 64'(n_disp), 64'd5);

      // killed head dropped, next committed entry dispatches
      iss(VADD, 4'd4, 32'h41, 32'h42, 1'b1);
      iss(VADD, 4'd5, 32'h51, 32'h52, 1'b1);
      cmt(4'd4, 1'b1, 1'b1);
      cmt(4'd5, 1'b0, 1'b1);
      repeat (2) idle(1'b1);
      chk("kill_disp_count", 64'(n_disp), 64'd6);

      // full queue, unknown commit id, live-id re-issue
      iss(VADD, 4'd10, 32'h1, 32'h1, 1'b1);
      iss(VADD, 4'd4, 32'h2, 32'h2, 1'b1);
      iss(VADD, 4'd11, 32'h3, 32'h3, 1'b1);
      iss(VADD, 4'd12, 32'h4, 32'h4, 1'b1);
      iss(VADD, 4'd13, 32'h5, 32'h5, 1'b1);
      cmt(4'd9, 1'b0, 1'b1);
      cmt(4'd10, 1'b0, 1'b1);
      idle(1'b1);
      iss(VADD, 4'd4, 32'h6, 32'h6, 1'b1);
      cmt(4'd4, 1'b0, 1'b0);

      // stalled dispatch holds data, then reset mid-way
      repeat (5) idle(1'b0);
      step(1'b1, 1'b0, 32'h0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // random traffic
      for (int cyc = 0; cyc < 4000; cyc++) begin
         case ($urandom_range(0, 3))
            0:       ins = VADD;
            1:       ins = VMVXS;
            2:       ins = ADDI;
            default: begin
               ins = $urandom();
               if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h57;
            end
         endcase
         waits.delete();
         foreach (mq[i]) if (mq[i].st == S_WAIT) waits.push_back(i);
         if (waits.size() > 0 && $urandom_range(0, 3) != 0) begin
            sel = waits[$urandom_range(0, waits.size() - 1)];
            cid = mq[sel].id;
         end else begin
            cid = IDW'($urandom_range(0, 15));
         end
         step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, ins,
              IDW'($urandom_range(0, 7)), $urandom(), $urandom(),
              $urandom_range(0, 2) != 0, cid, $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vec_xif_issue_queue.md
Name: vec_xif_issue_queue

Overview:
- Coprocessor-side front end of the X-interface. Sits directly downstream of the CPU's issue and commit channels.
- Decodes each offloaded instruction for accept/writeback, buffers accepted instructions with their operands, and waits for each one's commit or kill.
- Dispatches committed instructions in program order to the vector execution unit.
- Kills are dropped silently.

Parameters:
- DEPTH, 4, number of in-flight entries (power of two, ≥2)
- ID_WIDTH, 4, X-IF instruction ID width
- RFR_WIDTH, 32, source operand width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  CPU issue request valid
- issue_ready  out  1  queue can take an issue transaction
- issue_instr  in  32  offloaded instruction
- issue_id  in  ID_WIDTH  instruction ID
- issue_rs0  in  RFR_WIDTH  source operand 0
- issue_rs1  in  RFR_WIDTH  source operand 1
- issue_accept  out  1  response: instruction accepted (same cycle as handshake)
- issue_writeback  out  1  response: instruction will write an integer rd
- commit_valid  in  1  commit transaction valid
- commit_id  in  ID_WIDTH  ID being committed/killed
- commit_kill  in  1  1 = kill, 0 = commit
- disp_valid  out  1  head entry committed, ready for execution
- disp_ready  in  1  vector unit takes entry
- disp_instr  out  32  dispatched instruction
- disp_id  out  ID_WIDTH  dispatched ID
- disp_rs0  out  RFR_WIDTH  dispatched operand 0
- disp_rs1  out  RFR_WIDTH  dispatched operand 1
- occupancy  out  $clog2(DEPTH)+1  live entry count

Behaviour:
- Reset (sync, active-high): all entries FREE; head/tail pointers = 0; occupancy = 0; disp_valid = 0; disp_* data = 0; issue_ready = 1.
- Entry states: FREE → WAIT (on enqueue) → COMMITTED or KILLED (on matching commit) → FREE (on pop).
- issue_ready = (occupancy != DEPTH). It does not depend on decode. A full queue stalls accepted and rejected instructions alike.

Decode (combinational on issue_instr):
- issue_accept = 1 iff all of:
  - opcode[6:0] = 7'h57 (OP-V);
  - no live entry holds issue_id.
- issue_writeback = issue_accept & funct3 = 3'b010 & funct6 = 6'b010000.
- Both outputs are meaningful only while issue_valid = 1; they are 0 otherwise.

Enqueue:
- On issue_valid & issue_ready & issue_accept, write {instr, id, rs0, rs1} at the tail, state WAIT, and advance the tail (wraps modulo DEPTH).
- A handshake with issue_accept = 0 consumes the request and stores nothing.

Commit:
- On commit_valid, the WAIT entry whose id = commit_id becomes KILLED if commit_kill = 1, else COMMITTED.
- A commit_id with no WAIT entry is ignored. This covers unknown IDs, FREE entries, and repeat commits.
- A commit in the same cycle as the enqueue of the same ID applies to the new entry, which lands directly in COMMITTED/KILLED.

Head handling:
- disp_valid is registered: 1 exactly while the head entry is COMMITTED.
- Dispatch pops on disp_valid & disp_ready.
- A KILLED head pops in one cycle with disp_valid = 0.
- A WAIT head blocks everything behind it (in order), even if later entries are committed.
- Earliest dispatch: the cycle after an issue+commit that hits an empty queue.
- disp_* data are held stable while disp_valid & !disp_ready.

Simultaneous events and counting:
- Pop and enqueue in the same cycle leave occupancy unchanged.
- In a full queue with a pop in progress, issue_ready stays 0 that cycle; no same-cycle bypass.
- occupancy counts WAIT + COMMITTED + KILLED entries.
- A reset asserted mid-operation discards all entries. No dispatch happens in the reset cycle or the cycle after.

Test Plan:
- Reset, then issue vadd (0x02008057) id=3 rs0=5 rs1=7 with commit id=3 kill=0 in the same cycle -> issue_accept=1, issue_writeback=0; next cycle disp_valid=1, disp_id=3, disp_rs0=5, disp_rs1=7; disp_ready=1 -> occupancy back to 0.
- Issue non-vector instruction 0x00000013 -> issue_accept=0, occupancy stays 0. Issue vmv.x.s (0x42002057) -> accept=1, writeback=1.
- Issue ids 1,2,3; commit 3 then 2 (not 1) -> disp_valid stays 0. Commit 1 -> dispatch order 1,2,3 over 3 cycles with disp_ready held at 1.
- Issue ids 4,5; kill 4, commit 5 -> id 4 popped with no dispatch, then disp_id=5 one cycle later.
- Fill DEPTH=4 entries -> issue_ready=0, occupancy=4. A commit to an unknown id=9 has no effect. Re-issuing live id=4 after one pop -> issue_accept=0.
- Hold disp_ready=0 for 5 cycles with a committed head -> disp_* stable. Assert rst mid-way -> next cycle disp_valid=0, occupancy=0, issue_ready=1.
